// File: rtl/rand_arbiter.sv
// rand_arbiter: shares one 256-bit random generator among NREQ requesters.
// After a seed load, the generator must advance GAP cycles before a word may
// be handed out. A round-robin pick then selects one requester, which gets
// the current generator word together with a one-cycle grant pulse.
module rand_arbiter #(
  parameter int NREQ = 4,
  parameter int GAP  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic              reseed,
  input  logic [255:0]      gen_data,
  output logic              gen_en,
  output logic              gen_load,
  output logic [NREQ-1:0]   gnt,
  output logic [255:0]      rnd_out,
  output logic              rnd_valid,
  output logic [31:0]       grant_cnt
);

  localparam int             PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]     GAP_LAST = 8'(GAP - 1);
  localparam logic [PW-1:0]  PTR_RST  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WARM  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        gap_q, gap_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [255:0]      rnd_q, rnd_d;
  logic              valid_q, valid_d;
  logic [31:0]       cnt_q, cnt_d;

  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     cand;

  // Round-robin search: start just after the last granted index and wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic: load, warm-up counting, and grant issue from READY.
  // A reseed overrides everything, including a grant decided this cycle.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      LOAD: begin
        gap_d   = 8'd0;
        state_d = WARM;
      end
      WARM: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GAP_LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        if (!reseed && pick_found) begin
          gnt_d[pick_idx] = 1'b1;
          rnd_d           = gen_data;
          valid_d         = 1'b1;
          cnt_d           = cnt_q + 32'd1;
          gap_d           = 8'd0;
          ptr_d           = pick_idx;
          state_d         = WARM;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    if (reseed) begin
      state_d = LOAD;
    end
  end

  // State and output registers; reset leaves the pointer on the last index
  // so that requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      gap_q   <= 8'd0;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Generator controls are straight decodes of the state register.
  assign gen_load  = (state_q == LOAD);
  assign gen_en    = (state_q == WARM) || (state_q == READY);
  assign gnt       = gnt_q;
  assign rnd_out   = rnd_q;
  assign rnd_valid = valid_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed bench for rand_arbiter (NREQ=4, GAP=64).
// Cycle numbering: the cycle in which rst is released is cycle 0 (LOAD),
// cycles 1..64 are WARM, cycle 65 is READY, and a grant shows in cycle 66.
// After a grant in cycle g, READY is g+64 and the next grant is g+65.
module tb_rand_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic         reseed;
  logic [255:0] gen_data;
  logic         gen_en;
  logic         gen_load;
  logic [3:0]   gnt;
  logic [255:0] rnd_out;
  logic         rnd_valid;
  logic [31:0]  grant_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rand_arbiter #(.NREQ(4), .GAP(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .reseed    (reseed),
    .gen_data  (gen_data),
    .gen_en    (gen_en),
    .gen_load  (gen_load),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid),
    .grant_cnt (grant_cnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator word seen in a given bench cycle; distinct per cycle.
  function automatic logic [255:0] word(input int c);
    logic [31:0] v;
    v = 32'(c) * 32'h9E37_79B9;
    return {v, ~v, v ^ 32'h5A5A_5A5A, ~v, v, 32'(c), v, ~v};
  endfunction

  // One comparison: counts it, and reports a failure with both values.
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: outputs are sampled at the falling edge, then the
  // generator word for the new cycle is driven.
  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    gen_data = word(cyc);
  endtask

  // Assert reset for two cycles and release it; returns the LOAD cycle.
  task automatic doReset(output int t0);
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    t0  = cyc;
  endtask

  // Wait (bounded) for the next grant and check who, when, and what word.
  task automatic waitGrant(input string tag, input logic [3:0] exp_gnt,
                           input int from_cyc, input int exp_off, output int got_cyc);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while ((gnt == 4'b0000) && (n < 200));
    got_cyc = cyc;
    checkOutput({tag, " gnt"}, 256'(gnt), 256'(exp_gnt));
    checkOutput({tag, " spacing"}, 256'(cyc - from_cyc), 256'(exp_off));
    checkOutput({tag, " rnd_valid"}, 256'(rnd_valid), 256'(1'b1));
    checkOutput({tag, " rnd_out"}, rnd_out, word(cyc - 1));
  endtask

  // Directed sequence covering reset, warm-up timing, round-robin order,
  // reseed priority, mid-operation reset, counter wrap and dropped requests.
  initial begin
    int t0;
    int g;
    int prev;
    int load_cyc;
    logic [3:0] exp_g;
    logic seen;

    rst      = 1'b1;
    req      = 4'b0000;
    reseed   = 1'b0;
    gen_data = word(0);
    applyStimulus();
    applyStimulus();

    checkOutput("rst gen_load", 256'(gen_load), 256'(1'b1));
    checkOutput("rst gen_en", 256'(gen_en), 256'(1'b0));
    checkOutput("rst gnt", 256'(gnt), 256'(4'b0000));
    checkOutput("rst rnd_valid", 256'(rnd_valid), 256'(1'b0));
    checkOutput("rst rnd_out", rnd_out, 256'(0));
    checkOutput("rst grant_cnt", 256'(grant_cnt), 256'(32'd0));

    // First grant after reset release with requester 0 asking.
    req = 4'b0001;
    rst = 1'b0;
    t0  = cyc;
    #1;
    checkOutput("c0 gen_load", 256'(gen_load), 256'(1'b1));
    checkOutput("c0 gen_en", 256'(gen_en), 256'(1'b0));
    applyStimulus();
    checkOutput("c1 gen_load", 256'(gen_load), 256'(1'b0));
    checkOutput("c1 gen_en", 256'(gen_en), 256'(1'b1));
    waitGrant("first", 4'b0001, t0, 66, g);
    req = 4'b0000;
    checkOutput("first grant_cnt", 256'(grant_cnt), 256'(32'd1));
    applyStimulus();
    checkOutput("first gnt drop", 256'(gnt), 256'(4'b0000));
    checkOutput("first valid drop", 256'(rnd_valid), 256'(1'b0));
    checkOutput("first rnd hold", rnd_out, word(g - 1));

    // All four requesting continuously: 0,1,2,3,0 at 65-cycle spacing.
    req = 4'b1111;
    doReset(t0);
    waitGrant("rr0", 4'b0001, t0, 66, g);
    for (int k = 1; k <= 4; k++) begin
      exp_g = 4'b0001 << (k % 4);
      prev  = g;
      waitGrant("rr", exp_g, prev, 65, g);
    end
    req = 4'b0000;
    checkOutput("rr grant_cnt", 256'(grant_cnt), 256'(32'd5));

    // Grant to 1, then 0101 pending: 2 is next, then wrap to 0.
    req  = 4'b0010;
    prev = g;
    waitGrant("wrap g1", 4'b0010, prev, 65, g);
    req  = 4'b0101;
    prev = g;
    waitGrant("wrap g2", 4'b0100, prev, 65, g);
    prev = g;
    waitGrant("wrap g0", 4'b0001, prev, 65, g);
    req = 4'b0000;
    checkOutput("wrap grant_cnt", 256'(grant_cnt), 256'(32'd8));

    // Reseed in a READY cycle beats a simultaneous request.
    repeat (70) applyStimulus();
    checkOutput("idle gen_en", 256'(gen_en), 256'(1'b1));
    checkOutput("idle gnt", 256'(gnt), 256'(4'b0000));
    req    = 4'b0010;
    reseed = 1'b1;
    applyStimulus();
    reseed   = 1'b0;
    load_cyc = cyc;
    checkOutput("reseed gnt", 256'(gnt), 256'(4'b0000));
    checkOutput("reseed valid", 256'(rnd_valid), 256'(1'b0));
    checkOutput("reseed gen_load", 256'(gen_load), 256'(1'b1));
    checkOutput("reseed rnd hold", rnd_out, word(g - 1));
    waitGrant("reseed", 4'b0010, load_cyc, 66, g);
    req = 4'b0000;
    checkOutput("reseed grant_cnt", 256'(grant_cnt), 256'(32'd9));

    // Reset in WARM at counter 30; pointer returns to 3, so 0110 grants 1.
    repeat (30) applyStimulus();
    req = 4'b0110;
    rst = 1'b1;
    #1;
    checkOutput("midrst gen_load", 256'(gen_load), 256'(1'b1));
    checkOutput("midrst gen_en", 256'(gen_en), 256'(1'b0));
    checkOutput("midrst gnt", 256'(gnt), 256'(4'b0000));
    checkOutput("midrst rnd_valid", 256'(rnd_valid), 256'(1'b0));
    checkOutput("midrst rnd_out", rnd_out, 256'(0));
    checkOutput("midrst grant_cnt", 256'(grant_cnt), 256'(32'd0));
    applyStimulus();
    rst = 1'b0;
    t0  = cyc;
    waitGrant("midrst", 4'b0010, t0, 66, g);
    req = 4'b0000;
    checkOutput("midrst grant_cnt1", 256'(grant_cnt), 256'(32'd1));

    // Grant counter wraps from all-ones to zero.
    applyStimulus();
    force dut.cnt_q = 32'hFFFF_FFFF;
    applyStimulus();
    release dut.cnt_q;
    #1;
    checkOutput("wrapcnt preset", 256'(grant_cnt), 256'(32'hFFFF_FFFF));
    req  = 4'b0001;
    prev = g;
    waitGrant("wrapcnt", 4'b0001, prev, 65, g);
    req = 4'b0000;
    checkOutput("wrapcnt grant_cnt", 256'(grant_cnt), 256'(32'd0));

    // A request withdrawn during WARM is never granted.
    req = 4'b1000;
    repeat (10) applyStimulus();
    req  = 4'b0000;
    seen = 1'b0;
    repeat (80) begin
      applyStimulus();
      if (gnt != 4'b0000) seen = 1'b1;
    end
    checkOutput("dropped req no gnt", 256'(seen), 256'(1'b0));
    checkOutput("dropped req grant_cnt", 256'(grant_cnt), 256'(32'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
